// File: rtl/fwd_ctrl_if.sv
// ID-stage decode fields in, EX-stage operand selects / stall control out.
// WB slot contents exposed for write-after-read visibility.
interface fwd_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] rs_i;
    logic [ADDR_W-1:0] rt_i;
    logic              rs_use_i;
    logic              rt_use_i;
    logic [ADDR_W-1:0] rd_i;
    logic              regwrite_i;
    logic              memread_i;
    logic              flush_i;
    logic [1:0]        fwA_o;
    logic [1:0]        fwB_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [ADDR_W-1:0] wb_rd_o;
    logic              wb_we_o;
    logic              wb_mr_o;

    modport master (
        output rs_i, rt_i, rs_use_i, rt_use_i, rd_i, regwrite_i, memread_i, flush_i,
        input  fwA_o, fwB_o, stall_o, stall_cnt_o, wb_rd_o, wb_we_o, wb_mr_o
    );

    modport slave (
        input  rs_i, rt_i, rs_use_i, rt_use_i, rd_i, regwrite_i, memread_i, flush_i,
        output fwA_o, fwB_o, stall_o, stall_cnt_o, wb_rd_o, wb_we_o, wb_mr_o
    );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding-select and load-use stall generation for the 5-stage pipeline.
// Latency: selects registered in ID, valid for the whole EX cycle; stall_o is combinational.
// Backpressure: stall_o holds PC/IF-ID for one cycle and bubbles EX; flush_i overrides stall.
module fwd_ctrl #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              mr;
    } slot_t;

    localparam slot_t      BUBBLE = '0;
    localparam logic [1:0] SEL_ID = 2'b00;
    localparam logic [1:0] SEL_WB = 2'b01;
    localparam logic [1:0] SEL_EX = 2'b10;

    slot_t            ex_q;
    slot_t            mem_q;
    slot_t            wb_q;
    slot_t            id_slot;
    logic [1:0]       fwa_q;
    logic [1:0]       fwb_q;
    logic [1:0]       fwa_nxt;
    logic [1:0]       fwb_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             hit_rs;
    logic             hit_rt;
    logic             stall;
    logic             insert_bubble;

    // The younger writer (EX slot) wins over MEM so the most recent value is forwarded.
    function automatic logic [1:0] pick_sel(
        input logic              use_op,
        input logic [ADDR_W-1:0] src,
        input slot_t             ex,
        input slot_t             mem
    );
        logic [1:0] sel;
        sel = SEL_ID;
        if (use_op && ex.we && (ex.rd != '0) && (ex.rd == src)) begin
            sel = SEL_EX;
        end else if (use_op && mem.we && (mem.rd != '0) && (mem.rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        id_slot       = '{rd: bus.rd_i, we: bus.regwrite_i, mr: bus.memread_i};
        hit_rs        = bus.rs_use_i && (bus.rs_i == ex_q.rd);
        hit_rt        = bus.rt_use_i && (bus.rt_i == ex_q.rd);
        stall         = ex_q.mr && ex_q.we && (ex_q.rd != '0) && (hit_rs || hit_rt)
                        && !bus.flush_i;
        insert_bubble = stall || bus.flush_i;
        fwa_nxt       = pick_sel(bus.rs_use_i, bus.rs_i, ex_q, mem_q);
        fwb_nxt       = pick_sel(bus.rt_use_i, bus.rt_i, ex_q, mem_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
            fwa_q <= SEL_ID;
            fwb_q <= SEL_ID;
            cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (insert_bubble) begin
                ex_q  <= BUBBLE;
                fwa_q <= SEL_ID;
                fwb_q <= SEL_ID;
            end else begin
                ex_q  <= id_slot;
                fwa_q <= fwa_nxt;
                fwb_q <= fwb_nxt;
            end
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwA_o       = fwa_q;
    assign bus.fwB_o       = fwb_q;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = cnt_q;
    assign bus.wb_rd_o     = wb_q.rd;
    assign bus.wb_we_o     = wb_q.we;
    assign bus.wb_mr_o     = wb_q.mr;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed plus random bench for fwd_ctrl against an instruction-history reference model.
module tb_fwd_ctrl;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int SCW = 2;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam int unsigned SCMAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic rst;

    fwd_ctrl_if #(.ADDR_W(AW), .CNT_W(CW))  bus ();
    fwd_ctrl_if #(.ADDR_W(AW), .CNT_W(SCW)) sbus ();

    fwd_ctrl #(.ADDR_W(AW), .CNT_W(CW))  dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
    fwd_ctrl #(.ADDR_W(AW), .CNT_W(SCW)) dut_s (.clk_i(clk), .rst_i(rst), .bus(sbus));

    assign sbus.rs_i       = bus.rs_i;
    assign sbus.rt_i       = bus.rt_i;
    assign sbus.rs_use_i   = bus.rs_use_i;
    assign sbus.rt_use_i   = bus.rt_use_i;
    assign sbus.rd_i       = bus.rd_i;
    assign sbus.regwrite_i = bus.regwrite_i;
    assign sbus.memread_i  = bus.memread_i;
    assign sbus.flush_i    = bus.flush_i;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          we;
        logic          mr;
    } ins_t;

    // hist[0] = instruction now in EX, hist[1] = in MEM, hist[2] = in WB
    ins_t        hist [3];
    logic [1:0]  e_fwa, e_fwb;
    int unsigned e_cnt, e_scnt;

    logic [AW-1:0] c_rs, c_rt, c_rd;
    logic          c_rsu, c_rtu, c_rw, c_mr, c_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        e_fwa  = 2'b00;
        e_fwb  = 2'b00;
        e_cnt  = 0;
        e_scnt = 0;
    endfunction

    function automatic logic [1:0] pred_sel(input logic u, input logic [AW-1:0] src);
        if (!u || src == 0) return 2'b00;
        for (int age = 0; age < 2; age++)
            if (hist[age].we && hist[age].rd == src) return (age == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic pred_stall();
        ins_t ld;
        ld = hist[0];
        if (c_fl || !ld.mr || !ld.we || ld.rd == 0) return 1'b0;
        return (c_rsu && c_rs == ld.rd) || (c_rtu && c_rt == ld.rd);
    endfunction

    task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic rsu, input logic rtu,
                         input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic fl);
        c_rs = rs; c_rt = rt; c_rsu = rsu; c_rtu = rtu;
        c_rd = rd; c_rw = rw; c_mr = mr; c_fl = fl;
        bus.rs_i = rs; bus.rt_i = rt; bus.rs_use_i = rsu; bus.rt_use_i = rtu;
        bus.rd_i = rd; bus.regwrite_i = rw; bus.memread_i = mr; bus.flush_i = fl;
    endtask

    task automatic comb_check();
        chk("stall_o", {31'd0, bus.stall_o}, {31'd0, pred_stall()});
        chk("s_stall_o", {31'd0, sbus.stall_o}, {31'd0, pred_stall()});
    endtask

    task automatic edge_check(output logic stalled);
        logic       s;
        logic [1:0] na, nb;
        s  = pred_stall();
        na = pred_sel(c_rsu, c_rs);
        nb = pred_sel(c_rtu, c_rt);
        @(posedge clk);
        #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (s || c_fl) ? ins_t'(0) : ins_t'{rd: c_rd, we: c_rw, mr: c_mr};
        e_fwa   = (s || c_fl) ? 2'b00 : na;
        e_fwb   = (s || c_fl) ? 2'b00 : nb;
        if (s && e_cnt < CMAX)   e_cnt++;
        if (s && e_scnt < SCMAX) e_scnt++;
        chk("fwA_o", 32'(bus.fwA_o), 32'(e_fwa));
        chk("fwB_o", 32'(bus.fwB_o), 32'(e_fwb));
        chk("stall_cnt_o", 32'(bus.stall_cnt_o), e_cnt);
        chk("s_stall_cnt_o", 32'(sbus.stall_cnt_o), e_scnt);
        chk("s_fwA_o", 32'(sbus.fwA_o), 32'(e_fwa));
        chk("wb_rd_o", 32'(bus.wb_rd_o), 32'(hist[2].rd));
        chk("wb_we_mr", {30'd0, bus.wb_we_o, bus.wb_mr_o}, {30'd0, hist[2].we, hist[2].mr});
        stalled = s;
        @(negedge clk);
    endtask

    task automatic cycle(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic rsu, input logic rtu,
                         input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic fl, output logic stalled);
        drive(rs, rt, rsu, rtu, rd, rw, mr, fl);
        #4;
        comb_check();
        edge_check(stalled);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_fwA"}, 32'(bus.fwA_o), 32'd0);
        chk({tag, "_fwB"}, 32'(bus.fwB_o), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.stall_cnt_o), 32'd0);
        chk({tag, "_scnt"}, 32'(sbus.stall_cnt_o), 32'd0);
    endtask

    logic st;
    logic held;
    logic [AW-1:0] r_rs, r_rt, r_rd;
    logic r_rsu, r_rtu, r_rw, r_mr;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        // EX->EX forward: add r3 ; sub rs=3 rt=4
        cycle(1, 2, 1, 1, 3, 1, 0, 0, st);
        cycle(3, 4, 1, 1, 8, 1, 0, 0, st);
        chk("exex_fwA", 32'(bus.fwA_o), 32'd2);
        chk("exex_fwB", 32'(bus.fwB_o), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, st);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, st);

        // MEM forward: r5 writer, independent, consumer
        cycle(1, 1, 1, 1, 5, 1, 0, 0, st);
        cycle(1, 1, 1, 1, 6, 1, 0, 0, st);
        cycle(5, 1, 1, 1, 9, 1, 0, 0, st);
        chk("mem_fwA", 32'(bus.fwA_o), 32'd1);

        // Priority: two r5 writers back to back
        cycle(1, 1, 1, 1, 5, 1, 0, 0, st);
        cycle(1, 1, 1, 1, 5, 1, 0, 0, st);
        cycle(5, 1, 1, 1, 9, 1, 0, 0, st);
        chk("prio_fwA", 32'(bus.fwA_o), 32'd2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, st);

        // Load-use: lw r7 ; add rt=7 (stalls once, then takes WB select)
        cycle(1, 0, 1, 0, 7, 1, 1, 0, st);
        cycle(1, 7, 1, 1, 10, 1, 0, 0, st);
        chk("lu_stalled", 32'(st), 32'd1);
        chk("lu_cnt", 32'(bus.stall_cnt_o), 32'd1);
        cycle(1, 7, 1, 1, 10, 1, 0, 0, st);
        chk("lu_release", 32'(st), 32'd0);
        chk("lu_fwB", 32'(bus.fwB_o), 32'd1);

        // r0 never forwards or stalls
        cycle(1, 1, 1, 1, 0, 1, 1, 0, st);
        cycle(0, 0, 1, 1, 11, 1, 0, 0, st);
        chk("r0_stall", 32'(st), 32'd0);
        chk("r0_fwA", 32'(bus.fwA_o), 32'd0);

        // Unused operand does not stall
        cycle(1, 1, 1, 1, 7, 1, 1, 0, st);
        cycle(1, 7, 1, 0, 12, 1, 0, 0, st);
        chk("unused_stall", 32'(st), 32'd0);
        chk("unused_fwB", 32'(bus.fwB_o), 32'd0);

        // Flush beats load-use stall
        cycle(1, 1, 1, 1, 2, 1, 1, 0, st);
        cycle(2, 1, 1, 1, 13, 1, 0, 1, st);
        chk("flush_stall", 32'(st), 32'd0);
        chk("flush_fwA", 32'(bus.fwA_o), 32'd0);
        chk("flush_cnt", 32'(bus.stall_cnt_o), 32'd1);

        // Narrow counter instance must saturate, not wrap
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 1, 1, 7, 1, 1, 0, st);
            cycle(7, 1, 1, 1, 14, 1, 0, 0, st);
            cycle(7, 1, 1, 1, 14, 1, 0, 0, st);
        end
        chk("sat_scnt", 32'(sbus.stall_cnt_o), SCMAX);
        chk("sat_cnt", 32'(bus.stall_cnt_o), 32'd5);

        // Asynchronous reset mid-cycle with a load in EX and a dependent in ID
        cycle(1, 1, 1, 1, 3, 1, 1, 0, st);
        drive(3, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
        #1;
        comb_check();
        edge_check(st);
        chk("post_rst_fwA", 32'(bus.fwA_o), 32'd0);

        // Random traffic; a stalled instruction is re-presented like a held IF/ID
        held = 1'b0;
        r_rs = 0; r_rt = 0; r_rd = 0; r_rsu = 0; r_rtu = 0; r_rw = 0; r_mr = 0;
        for (int i = 0; i < 600; i++) begin
            if (!held) begin
                r_rs  = AW'($urandom_range(7));
                r_rt  = AW'($urandom_range(7));
                r_rd  = AW'($urandom_range(7));
                r_rsu = 1'($urandom_range(1));
                r_rtu = 1'($urandom_range(1));
                r_rw  = ($urandom_range(3) != 0);
                r_mr  = ($urandom_range(2) == 0);
            end
            cycle(r_rs, r_rt, r_rsu, r_rtu, r_rd, r_rw, r_mr, ($urandom_range(7) == 0), held);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
